// File: rtl/sonar_wb_interconnect.sv
// ---------------------------------------------------------------------------
// sonar_wb_interconnect
//
// Wishbone slave-side controller that sits between the caravel management
// Wishbone port and NSLV internal SonarOnChip peripherals. It decodes the
// address window, runs exactly one transaction at a time towards one
// peripheral, and returns a registered ack plus read data to the master.
// Requests outside the window are acknowledged at once with zero data.
//
// Optional feature (macro SONAR_WBIC_TIMEOUT_EN): a BUSY-cycle counter that
// forcibly terminates a transaction to a hung peripheral after TIMEOUT
// cycles, returning ERR_DATA and pulsing timeout_o. Without the macro a
// transaction waits for the peripheral indefinitely and timeout_o is 0.
//
// Ports
//   wb_clk_i            clock
//   wb_rst_i            synchronous active-high reset
//   wbs_cyc_i/stb_i     master cycle / strobe
//   wbs_we_i            master write enable
//   wbs_sel_i  [3:0]    master byte selects
//   wbs_adr_i  [31:0]   master address
//   wbs_dat_i  [31:0]   master write data
//   wbs_ack_o           registered ack, one cycle per transaction
//   wbs_dat_o  [31:0]   registered read data
//   slv_cyc_o  [NSLV]   one-hot per-peripheral cycle
//   slv_stb_o  [NSLV]   one-hot per-peripheral strobe
//   slv_we_o, slv_sel_o, slv_adr_o, slv_dat_o   latched shared request
//   slv_ack_i  [NSLV]   per-peripheral ack
//   slv_dat_i  [32*NSLV] per-peripheral read data, slave k at [32k +: 32]
//   timeout_o           one-cycle pulse on forced termination
// ---------------------------------------------------------------------------
module sonar_wb_interconnect #(
    parameter int          IDX_W    = 2,
    parameter logic [15:0] BASE_HI  = 16'h3000,
    parameter int          IDX_LSB  = 8,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hBADC0DE5,
    localparam int         NSLV     = 2**IDX_W
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NSLV-1:0]      slv_cyc_o,
    output logic [NSLV-1:0]      slv_stb_o,
    output logic                 slv_we_o,
    output logic [3:0]           slv_sel_o,
    output logic [31:0]          slv_adr_o,
    output logic [31:0]          slv_dat_o,
    input  logic [NSLV-1:0]      slv_ack_i,
    input  logic [32*NSLV-1:0]   slv_dat_i,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request fields and response registers
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [NSLV-1:0]  stb_q, stb_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdat_q, rdat_d;

    logic             req;
    logic             hit;
    logic             sel_ack;
    logic             tmo_hit;
    logic [NSLV-1:0]  idx_dec;
    logic [31:0]      slv_rdata [NSLV];

    assign req = wbs_cyc_i & wbs_stb_i;
    assign hit = (wbs_adr_i[31:16] == BASE_HI);

    // Per-slave read-data view and one-hot decode of the latched index
    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_slv
            assign slv_rdata[gi] = slv_dat_i[32*gi +: 32];
            assign idx_dec[gi]   = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Only the selected slave's ack counts, and only once it is strobed.
    assign sel_ack = slv_ack_i[idx_q] & stb_q[idx_q];

`ifdef SONAR_WBIC_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    // Ack in the terminal count cycle wins over the timeout.
    assign tmo_hit   = (cnt_q == 8'(TIMEOUT - 1)) && !sel_ack;
    assign timeout_o = tmo_q;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (state_q == S_IDLE && req && hit) begin
            cnt_d = 8'd0;
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q + 8'd1;
            tmo_d = tmo_hit;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = hit ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (sel_ack || tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath next-state logic ----------------
    // The shared request fields are latched on the accepting edge and the
    // strobe follows one cycle later, so peripherals always see address,
    // data and selects settled for a full cycle before their strobe.
    always_comb begin
        idx_d  = idx_q;
        we_d   = we_q;
        sel_d  = sel_q;
        adr_d  = adr_q;
        wdat_d = wdat_q;
        stb_d  = stb_q;
        ack_d  = 1'b0;
        rdat_d = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        idx_d  = wbs_adr_i[IDX_LSB +: IDX_W];
                        we_d   = wbs_we_i;
                        sel_d  = wbs_sel_i;
                        adr_d  = wbs_adr_i;
                        wdat_d = wbs_dat_i;
                    end else begin
                        ack_d  = 1'b1;
                        rdat_d = 32'd0;
                    end
                end
            end
            S_BUSY: begin
                if (stb_q == '0) begin
                    // First BUSY cycle: raise the strobe for the chosen slave.
                    stb_d = idx_dec;
                end else if (sel_ack) begin
                    stb_d  = '0;
                    ack_d  = 1'b1;
                    rdat_d = we_q ? 32'd0 : slv_rdata[idx_q];
                end else if (tmo_hit) begin
                    stb_d  = '0;
                    ack_d  = 1'b1;
                    rdat_d = ERR_DATA;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            idx_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= 4'd0;
            adr_q  <= 32'd0;
            wdat_q <= 32'd0;
            stb_q  <= '0;
            ack_q  <= 1'b0;
            rdat_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            adr_q  <= adr_d;
            wdat_q <= wdat_d;
            stb_q  <= stb_d;
            ack_q  <= ack_d;
            rdat_q <= rdat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign slv_cyc_o = stb_q;
    assign slv_stb_o = stb_q;
    assign slv_we_o  = we_q;
    assign slv_sel_o = sel_q;
    assign slv_adr_o = adr_q;
    assign slv_dat_o = wdat_q;

endmodule

// File: tb/tb_sonar_wb_interconnect.sv
// ---------------------------------------------------------------------------
// Testbench for sonar_wb_interconnect. A master driver issues transactions
// and pushes the expected response into a scoreboard queue; a monitor pops
// and compares on every wbs_ack_o and checks the per-slave strobes against
// the expected strobe window. Behavioural slaves respond after a chosen
// delay; unselected slaves can raise spurious acks.
// ---------------------------------------------------------------------------
module tb_sonar_wb_interconnect;

`ifdef SONAR_WBIC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'd0;
    logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  slv_cyc_o, slv_stb_o;
    logic        slv_we_o;
    logic [3:0]  slv_sel_o;
    logic [31:0] slv_adr_o, slv_dat_o;
    logic [3:0]  slv_ack_i = 4'd0;
    logic [127:0] slv_dat_i = 128'd0;
    logic        timeout_o;

    always #5 wb_clk_i = ~wb_clk_i;

    sonar_wb_interconnect dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .slv_cyc_o(slv_cyc_o), .slv_stb_o(slv_stb_o), .slv_we_o(slv_we_o),
        .slv_sel_o(slv_sel_o), .slv_adr_o(slv_adr_o), .slv_dat_o(slv_dat_o),
        .slv_ack_i(slv_ack_i), .slv_dat_i(slv_dat_i), .timeout_o(timeout_o)
    );

    int checks = 0, failures = 0, cyc_cnt = 0, ack_count = 0;
    bit mon_en = 1'b0;

    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [31:0] data;
        logic        tmo;
        int          s;
        int          lat;
        logic [31:0] adr;
    } exp_t;
    exp_t exp_q[$];

    // Expected strobe window (inclusive cycle range) and latched fields
    int          win_lo = 1, win_hi = 0;
    logic [3:0]  win_mask = 4'd0;
    logic [31:0] win_adr = 32'd0, win_dat = 32'd0;
    logic        win_we = 1'b0;
    logic [3:0]  win_sel = 4'd0;

    // Behavioural slave controls
    int          cur_idx = -1, cur_delay = 0, scnt = 0;
    bit          cur_hang = 1'b0, spur_en = 1'b0;
    logic [31:0] cur_rdata = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @cycle %0d", nm, act, req, cyc_cnt);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            logic [3:0] es;
            exp_t e;
            es = (cyc_cnt >= win_lo && cyc_cnt <= win_hi) ? win_mask : 4'd0;
            chk("slv_stb", {28'd0, slv_stb_o}, {28'd0, es});
            chk("slv_cyc", {28'd0, slv_cyc_o}, {28'd0, es});
            if (es != 4'd0) begin
                chk("slv_adr", slv_adr_o, win_adr);
                chk("slv_dat", slv_dat_o, win_dat);
                chk("slv_we",  {31'd0, slv_we_o}, {31'd0, win_we});
                chk("slv_sel", {28'd0, slv_sel_o}, {28'd0, win_sel});
            end
            if (wbs_ack_o === 1'b1) begin
                ack_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack actual=1 required=0 dat_o=%h", wbs_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_data", wbs_dat_o, e.data);
                    chk("ack_latency", 32'(cyc_cnt - e.s + 1), 32'(e.lat));
                    chk("timeout_flag", {31'd0, timeout_o}, {31'd0, e.tmo});
                    $display("txn adr=%h dat_o=%h tmo=%b lat=%0d", e.adr, wbs_dat_o,
                             timeout_o, cyc_cnt - e.s + 1);
                end
            end else begin
                chk("timeout_no_ack", {31'd0, timeout_o}, 32'd0);
            end
        end
    end

    // ---------------- behavioural slaves ----------------
    always @(posedge wb_clk_i) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k == cur_idx) begin
                if (slv_stb_o[k]) begin
                    slv_ack_i[k] = !cur_hang && (scnt == cur_delay);
                    slv_dat_i[32*k +: 32] = cur_rdata;
                    scnt++;
                end else begin
                    slv_ack_i[k] = 1'b0;
                    slv_dat_i[32*k +: 32] = $urandom;
                    scnt = 0;
                end
            end else begin
                slv_ack_i[k] = spur_en;
                slv_dat_i[32*k +: 32] = $urandom;
            end
        end
    end

    // Reset while a transaction is in flight; called at posedge+1.
    task automatic reset_mid();
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        win_hi    = cyc_cnt;
        @(posedge wb_clk_i); #1;
        chk("rst_stb", {28'd0, slv_stb_o}, 32'd0);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        wb_rst_i = 1'b0;
        cur_idx  = -1;
    endtask

    // One master transaction; entered and left at posedge+1.
    task automatic do_txn(input logic [31:0] a, input bit w, input logic [31:0] wd,
                          input logic [3:0] s4, input int dly, input bit hang,
                          input logic [31:0] rd, input bit abort, input int rst_after);
        bit   hit;
        int   idx, s;
        bit   seen;
        exp_t e;
        hit       = (a[31:16] == 16'h3000);
        idx       = int'(a[9:8]);
        cur_idx   = hit ? idx : -1;
        cur_delay = dly;
        cur_hang  = hang;
        cur_rdata = rd;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a;    wbs_dat_i = wd;   wbs_sel_i = s4;
        @(posedge wb_clk_i); #1;
        s = cyc_cnt;
        if (hit) begin
            win_mask = 4'b0001 << idx;
            win_adr  = a; win_dat = wd; win_we = w; win_sel = s4;
            win_lo   = s + 1;
            if (hang) win_hi = TMO_EN ? s + 15 : s + 1000000;
            else      win_hi = s + 1 + dly;
        end
        e.s = s; e.adr = a;
        if (!hit)      begin e.data = 32'd0;         e.tmo = 1'b0; e.lat = 1;       end
        else if (hang) begin e.data = 32'hBADC0DE5;  e.tmo = 1'b1; e.lat = 17;      end
        else           begin e.data = w ? 32'd0 : rd; e.tmo = 1'b0; e.lat = 3 + dly; end
        if (abort) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
        if (rst_after >= 0) begin
            repeat (rst_after) begin @(posedge wb_clk_i); #1; end
            reset_mid();
        end else begin
            exp_q.push_back(e);
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge wb_clk_i);
                if (wbs_ack_o === 1'b1) seen = 1'b1;
            end
            chk("ack_seen", {31'd0, seen}, 32'd1);
            // Request is still held through the ack cycle, which must not re-issue.
            @(posedge wb_clk_i); #1;
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            cur_idx   = -1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("reset_dat", wbs_dat_o, 32'd0);
        chk("reset_stb", {28'd0, slv_stb_o}, 32'd0);
        chk("reset_cyc", {28'd0, slv_cyc_o}, 32'd0);
        chk("reset_fields", slv_adr_o | slv_dat_o | {27'd0, slv_we_o, slv_sel_o}, 32'd0);
        chk("reset_timeout", {31'd0, timeout_o}, 32'd0);
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;
        @(posedge wb_clk_i); #1;

        // Directed cases
        do_txn(32'h3000_0104, 1'b1, 32'h1234_5678, 4'hF, 2, 1'b0, 32'h0, 1'b0, -1);
        do_txn(32'h3000_0300, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE_F00D, 1'b0, -1);
        do_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0, -1);
        spur_en = 1'b1;
        do_txn(32'h3000_0210, 1'b0, 32'h0, 4'h3, 4, 1'b0, 32'h5A5A_0F0F, 1'b0, -1);
        spur_en = 1'b0;
        do_txn(32'h3000_0008, 1'b0, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_BEEF, 1'b1, -1);
`ifdef SONAR_WBIC_TIMEOUT_EN
        do_txn(32'h3000_0200, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h1111_2222, 1'b0, -1);
        do_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h7654_3210, 1'b0, -1);
`else
        a0 = ack_count;
        do_txn(32'h3000_0200, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h1111_2222, 1'b0, 100);
        chk("hang_no_ack", 32'(ack_count - a0), 32'd0);
`endif
        // Reset in BUSY with the strobe up, then a normal read
        do_txn(32'h3000_0100, 1'b0, 32'h0, 4'hF, 5, 1'b0, 32'hDEAD_0001, 1'b0, 2);
        do_txn(32'h3000_0100, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hFEED_0002, 1'b0, -1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            bit          hang;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[31:16] = 16'h3000;
            else if (a[31:16] == 16'h3000) a[31] = 1'b1;
            hang = 1'b0;
`ifdef SONAR_WBIC_TIMEOUT_EN
            hang = ($urandom_range(0, 14) == 0);
`endif
            spur_en = ($urandom_range(0, 2) == 0);
            do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 5), hang, $urandom,
                   ($urandom_range(0, 9) == 0), -1);
            repeat ($urandom_range(0, 2)) begin @(posedge wb_clk_i); #1; end
        end
        spur_en = 1'b0;

        repeat (5) @(posedge wb_clk_i);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
